// File: rtl/rx_trace_pkg.sv
// rx_trace_pkg: shared FSM encoding and entry-width helper for the receiver state trace.
//   No ports; imported by rx_state_trace.
package rx_trace_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      POST   = 2'd1,
      FROZEN = 2'd2
   } fsm_t;

   // Width of one stored entry: {timestamp, state}.
   function automatic int entry_width(input int ts_w, input int st_w);
      return ts_w + st_w;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port storage with one write port and a registered read port.
//   clk       : clock
//   we        : write enable
//   waddr     : write address
//   wdata     : write data
//   raddr     : read address, sampled on the clock edge
//   rd_data_q : read data, returns pre-write contents when both ports hit one address
module trace_ram #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rd_data_q
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rd_data_q <= mem[raddr];
   end

endmodule

// File: rtl/rx_state_trace.sv
// rx_state_trace: timestamped ring-buffer trace of receiver state changes with trigger/freeze.
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   state, state_changed           : state code and its change strobe
//   trig, arm, clear               : trigger, resume-from-frozen, empty buffer
//   rd_idx -> rd_data              : 1-cycle read, index 0 is the newest entry
//   entry_count, frozen, drop_count, history_packed : registered status
module rx_state_trace
   import rx_trace_pkg::*;
#(
   parameter int STATE_WIDTH = 4,
   parameter int DEPTH       = 16,
   parameter int TS_WIDTH    = 16,
   parameter int POST_TRIG   = 8
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [STATE_WIDTH-1:0]            state,
   input  logic                              state_changed,
   input  logic                              trig,
   input  logic                              arm,
   input  logic                              clear,
   input  logic [$clog2(DEPTH)-1:0]          rd_idx,
   output logic [TS_WIDTH+STATE_WIDTH-1:0]   rd_data,
   output logic [$clog2(DEPTH):0]            entry_count,
   output logic                              frozen,
   output logic [15:0]                       drop_count,
   output logic [31:0]                       history_packed
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = entry_width(TS_WIDTH, STATE_WIDTH);
   localparam int HW = (32 / STATE_WIDTH) * STATE_WIDTH;
   localparam logic [63:0] HMASK64 = (64'd1 << HW) - 64'd1;
   localparam logic [31:0] HMASK = HMASK64[31:0];
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   fsm_t              fsm_q, fsm_d;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     post_cnt_q, post_cnt_d;
   logic [AW:0]       entry_count_q, entry_count_d;
   logic [15:0]       drop_q, drop_d;
   logic [31:0]       hist_q, hist_d;
   logic              frozen_q, frozen_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rec;
   logic [EW-1:0]     ram_rd;

   always_comb begin
      rec           = state_changed && !clear && fsm_q != FROZEN;
      ts_d          = ts_q + 1'b1;
      fsm_d         = fsm_q;
      post_cnt_d    = post_cnt_q;
      wr_ptr_d      = rec ? wr_ptr_q + 1'b1 : wr_ptr_q;
      entry_count_d = (rec && entry_count_q != FULL) ? entry_count_q + 1'b1 : entry_count_q;
      drop_d        = (state_changed && fsm_q == FROZEN && drop_q != 16'hFFFF) ? drop_q + 1'b1 : drop_q;
      hist_d        = rec ? ((hist_q << STATE_WIDTH) | 32'(state)) & HMASK : hist_q;
      // The write coinciding with trig is recorded but does not consume a post slot.
      if (fsm_q == RUN && trig) begin
         fsm_d      = (POST_TRIG == 0) ? FROZEN : POST;
         post_cnt_d = AW'(POST_TRIG);
      end
      if (fsm_q == POST && rec) begin
         post_cnt_d = post_cnt_q - 1'b1;
         fsm_d      = (post_cnt_q == AW'(1)) ? FROZEN : POST;
      end
      if (fsm_q == FROZEN && arm) fsm_d = RUN;
      if (clear) begin
         fsm_d         = RUN;
         post_cnt_d    = '0;
         wr_ptr_d      = '0;
         entry_count_d = '0;
         drop_d        = '0;
         hist_d        = '0;
      end
      frozen_d   = fsm_d == FROZEN;
      rd_valid_d = {1'b0, rd_idx} < entry_count_q;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         fsm_q         <= RUN;
         ts_q          <= '0;
         wr_ptr_q      <= '0;
         post_cnt_q    <= '0;
         entry_count_q <= '0;
         drop_q        <= '0;
         hist_q        <= '0;
         frozen_q      <= 1'b0;
         rd_valid_q    <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         ts_q          <= ts_d;
         wr_ptr_q      <= wr_ptr_d;
         post_cnt_q    <= post_cnt_d;
         entry_count_q <= entry_count_d;
         drop_q        <= drop_d;
         hist_q        <= hist_d;
         frozen_q      <= frozen_d;
         rd_valid_q    <= rd_valid_d;
      end
   end

   trace_ram #(.WIDTH(EW), .DEPTH(DEPTH)) u_ram (
      .clk       (s00_axi_aclk),
      .we        (rec),
      .waddr     (wr_ptr_q),
      .wdata     ({ts_q, state}),
      .raddr     (wr_ptr_q - 1'b1 - rd_idx),
      .rd_data_q (ram_rd)
   );

   // The valid flag is reset, so rd_data reads 0 without resetting the array.
   assign rd_data        = rd_valid_q ? ram_rd : '0;
   assign entry_count    = entry_count_q;
   assign frozen         = frozen_q;
   assign drop_count     = drop_q;
   assign history_packed = hist_q;

endmodule

// File: tb/tb_rx_state_trace.sv
// tb_rx_state_trace: directed self-checking bench for rx_state_trace.
module tb_rx_state_trace;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  state = '0;
   logic        state_changed = 1'b0, trig = 1'b0, arm = 1'b0, clear = 1'b0;
   logic [3:0]  rd_idx = '0;
   logic [19:0] rd_data, rd_data0;
   logic [4:0]  entry_count, entry_count0;
   logic        frozen, frozen0;
   logic [15:0] drop_count, drop_count0;
   logic [31:0] history_packed, history_packed0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   rx_state_trace #(.STATE_WIDTH(4), .DEPTH(16), .TS_WIDTH(16), .POST_TRIG(8)) u_dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .state(state), .state_changed(state_changed),
      .trig(trig), .arm(arm), .clear(clear), .rd_idx(rd_idx), .rd_data(rd_data),
      .entry_count(entry_count), .frozen(frozen), .drop_count(drop_count), .history_packed(history_packed));

   rx_state_trace #(.STATE_WIDTH(4), .DEPTH(16), .TS_WIDTH(16), .POST_TRIG(0)) u_dut0 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .state(state), .state_changed(state_changed),
      .trig(trig), .arm(arm), .clear(clear), .rd_idx(rd_idx), .rd_data(rd_data0),
      .entry_count(entry_count0), .frozen(frozen0), .drop_count(drop_count0), .history_packed(history_packed0));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      state_changed = 0; trig = 0; arm = 0; clear = 0; rd_idx = 0;
      rst_n = 0;
      tick; tick;
      rst_n = 1;
      tick;
   endtask

   task automatic wr(input logic [3:0] s);
      state = s; state_changed = 1;
      tick;
      state_changed = 0;
   endtask

   task automatic rd(input logic [3:0] idx, output logic [19:0] d);
      rd_idx = idx;
      tick;
      d = rd_data;
   endtask

   task automatic test_reset;
      #1 rst_n = 0;
      #2;
      checks++; if (entry_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", entry_count); end
      checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen got %0b exp 0", frozen); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
      checks++; if (history_packed !== 32'd0) begin errors++; $display("FAIL reset_hist got %h exp 0", history_packed); end
      checks++; if (rd_data !== 20'd0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd_data); end
      tick;
      rst_n = 1;
      tick;
   endtask

   task automatic test_basic;
      logic [19:0] d0, d1, d2, d3;
      do_reset;
      wr(4'd1); repeat (9) tick;
      wr(4'd2); repeat (9) tick;
      wr(4'd3);
      checks++; if (entry_count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", entry_count); end
      checks++; if (history_packed !== 32'h0000_0123) begin errors++; $display("FAIL basic_hist got %h exp 00000123", history_packed); end
      rd(4'd0, d0); rd(4'd1, d1); rd(4'd2, d2); rd(4'd3, d3);
      checks++; if (d0[3:0] !== 4'd3) begin errors++; $display("FAIL basic_idx0 got %0d exp 3", d0[3:0]); end
      checks++; if (d1[3:0] !== 4'd2) begin errors++; $display("FAIL basic_idx1 got %0d exp 2", d1[3:0]); end
      checks++; if (d2[3:0] !== 4'd1) begin errors++; $display("FAIL basic_idx2 got %0d exp 1", d2[3:0]); end
      checks++; if (d0[19:4] - d1[19:4] !== 16'd10) begin errors++; $display("FAIL basic_ts01 got %0d exp 10", d0[19:4] - d1[19:4]); end
      checks++; if (d1[19:4] - d2[19:4] !== 16'd10) begin errors++; $display("FAIL basic_ts12 got %0d exp 10", d1[19:4] - d2[19:4]); end
      checks++; if (d3 !== 20'd0) begin errors++; $display("FAIL basic_idx3_empty got %h exp 0", d3); end
   endtask

   task automatic test_wrap;
      logic [19:0] d0, d15;
      do_reset;
      for (int i = 1; i <= 20; i++) wr(4'(i));
      checks++; if (entry_count !== 5'd16) begin errors++; $display("FAIL wrap_count got %0d exp 16", entry_count); end
      checks++; if (history_packed !== 32'hDEF0_1234) begin errors++; $display("FAIL wrap_hist got %h exp def01234", history_packed); end
      rd(4'd0, d0); rd(4'd15, d15);
      checks++; if (d0[3:0] !== 4'd4) begin errors++; $display("FAIL wrap_idx0 got %0d exp 4", d0[3:0]); end
      checks++; if (d15[3:0] !== 4'd5) begin errors++; $display("FAIL wrap_idx15 got %0d exp 5", d15[3:0]); end
      checks++; if (d0[19:4] - d15[19:4] !== 16'd15) begin errors++; $display("FAIL wrap_ts got %0d exp 15", d0[19:4] - d15[19:4]); end
   endtask

   task automatic test_trigger;
      logic [19:0] d0;
      do_reset;
      for (int i = 1; i <= 5; i++) wr(4'(i));
      trig = 1; wr(4'd6); trig = 0;
      for (int i = 7; i <= 16; i++) wr(4'(i));
      checks++; if (entry_count !== 5'd14) begin errors++; $display("FAIL trig_count got %0d exp 14", entry_count); end
      checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL trig_frozen got %0b exp 1", frozen); end
      checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL trig_drop got %0d exp 2", drop_count); end
      checks++; if (history_packed !== 32'h789A_BCDE) begin errors++; $display("FAIL trig_hist got %h exp 789abcde", history_packed); end
      trig = 1; tick; trig = 0;
      rd(4'd0, d0);
      checks++; if (d0[3:0] !== 4'hE) begin errors++; $display("FAIL trig_idx0 got %0d exp 14", d0[3:0]); end
   endtask

   task automatic test_arm;
      arm = 1; tick; arm = 0;
      checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL arm_frozen got %0b exp 0", frozen); end
      wr(4'd3);
      checks++; if (entry_count !== 5'd15) begin errors++; $display("FAIL arm_count got %0d exp 15", entry_count); end
      checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL arm_drop got %0d exp 2", drop_count); end
      checks++; if (history_packed !== 32'h89AB_CDE3) begin errors++; $display("FAIL arm_hist got %h exp 89abcde3", history_packed); end
   endtask

   task automatic test_clear;
      logic [19:0] d0;
      trig = 1; tick; trig = 0;
      for (int i = 1; i <= 8; i++) wr(4'(i));
      checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL clr_pre_frozen got %0b exp 1", frozen); end
      clear = 1; arm = 1; state = 4'd5; state_changed = 1;
      tick;
      clear = 0; arm = 0; state_changed = 0;
      checks++; if (entry_count !== 5'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", entry_count); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL clr_drop got %0d exp 0", drop_count); end
      checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL clr_frozen got %0b exp 0", frozen); end
      checks++; if (history_packed !== 32'd0) begin errors++; $display("FAIL clr_hist got %h exp 0", history_packed); end
      rd(4'd0, d0);
      checks++; if (d0 !== 20'd0) begin errors++; $display("FAIL clr_rd got %h exp 0", d0); end
      wr(4'd9);
      rd(4'd0, d0);
      checks++; if (d0[3:0] !== 4'd9) begin errors++; $display("FAIL clr_first_wr got %0d exp 9", d0[3:0]); end
   endtask

   task automatic test_async_reset;
      logic [19:0] d0;
      do_reset;
      trig = 1; tick; trig = 0;
      wr(4'd7); wr(4'd8);
      rd(4'd0, d0);
      checks++; if (d0[3:0] !== 4'd8) begin errors++; $display("FAIL ar_pre_rd got %0d exp 8", d0[3:0]); end
      #2 rst_n = 0;
      #1;
      checks++; if (entry_count !== 5'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", entry_count); end
      checks++; if (history_packed !== 32'd0) begin errors++; $display("FAIL ar_hist got %h exp 0", history_packed); end
      checks++; if (rd_data !== 20'd0) begin errors++; $display("FAIL ar_rd got %h exp 0", rd_data); end
      checks++; if (frozen0 !== 1'b0) begin errors++; $display("FAIL ar_frozen0 got %0b exp 0", frozen0); end
      checks++; if (drop_count0 !== 16'd0) begin errors++; $display("FAIL ar_drop0 got %0d exp 0", drop_count0); end
      rst_n = 1;
      tick;
      trig = 1; tick; trig = 0;
      checks++; if (frozen0 !== 1'b1) begin errors++; $display("FAIL ar_pt0_frozen got %0b exp 1", frozen0); end
      checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL ar_pt8_frozen got %0b exp 0", frozen); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_wrap;
      test_trigger;
      test_arm;
      test_clear;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
